// File: rtl/piso_feeder_if.sv
// Handshake and serial-output bundle between a word producer, the PISO feeder
// and the downstream serial-in shift register.
interface piso_feeder_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] s_data;
    logic             s_valid;
    logic             s_ready;
    logic             hold;
    logic             ser_d;
    logic             ser_en;
    logic             word_done;

    modport master (
        output s_data,
        output s_valid,
        output hold,
        input  s_ready,
        input  ser_d,
        input  ser_en,
        input  word_done
    );

    modport slave (
        input  s_data,
        input  s_valid,
        input  hold,
        output s_ready,
        output ser_d,
        output ser_en,
        output word_done
    );
endinterface

// File: rtl/piso_word_buf.sv
// One-entry holding buffer; a take always wins over a write because the feeder
// only writes while the buffer is empty and only takes while it is full.
module piso_word_buf #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             out_take,
    output logic             full,
    output logic [WIDTH-1:0] out_data
);
    logic             full_r;
    logic [WIDTH-1:0] data_r;

    // Buffer occupancy flag and stored word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_r <= 1'b0;
            data_r <= '0;
        end else if (out_take) begin
            full_r <= 1'b0;
        end else if (in_valid) begin
            full_r <= 1'b1;
            data_r <= in_data;
        end else begin
            full_r <= full_r;
        end
    end

    assign full     = full_r;
    assign out_data = data_r;
endmodule

// File: rtl/piso_feeder.sv
// Parallel-in serial-out feeder: streams accepted words LSB first into a
// downstream serial-in shift register, with a one-word buffer for gapless flow.
module piso_feeder #(
    parameter int WIDTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    piso_feeder_if.slave bus
);
    localparam int             CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] sh_r;
    logic [CNT_W-1:0] cnt_r;
    logic             busy_r;

    logic             buf_full_s;
    logic [WIDTH-1:0] buf_data_s;

    logic             ser_en_s;
    logic             done_s;
    logic             free_s;
    logic             accept_s;
    logic             load_s;
    logic [WIDTH-1:0] load_data_s;
    logic             buf_wr_s;
    logic             buf_take_s;

    piso_word_buf #(.WIDTH(WIDTH)) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (buf_wr_s),
        .in_data  (bus.s_data),
        .out_take (buf_take_s),
        .full     (buf_full_s),
        .out_data (buf_data_s)
    );

    // Handshake decode: a buffered word always drains before a new one is taken.
    always_comb begin
        ser_en_s    = busy_r && !bus.hold;
        done_s      = ser_en_s && (cnt_r == LAST_CNT);
        free_s      = !busy_r || done_s;
        accept_s    = bus.s_valid && !buf_full_s;
        load_s      = 1'b0;
        load_data_s = '0;
        buf_wr_s    = 1'b0;
        buf_take_s  = 1'b0;
        if (free_s && buf_full_s) begin
            load_s      = 1'b1;
            load_data_s = buf_data_s;
            buf_take_s  = 1'b1;
        end else if (free_s && accept_s) begin
            load_s      = 1'b1;
            load_data_s = bus.s_data;
        end else if (accept_s) begin
            buf_wr_s    = 1'b1;
        end else begin
            buf_wr_s    = 1'b0;
        end
    end

    // Shifter: load, complete (clearing data so idle ser_d reads 0), or shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_r   <= '0;
            cnt_r  <= '0;
            busy_r <= 1'b0;
        end else if (load_s) begin
            sh_r   <= load_data_s;
            cnt_r  <= '0;
            busy_r <= 1'b1;
        end else if (done_s) begin
            sh_r   <= '0;
            cnt_r  <= '0;
            busy_r <= 1'b0;
        end else if (ser_en_s) begin
            sh_r   <= sh_r >> 1;
            cnt_r  <= cnt_r + CNT_W'(1);
        end else begin
            sh_r   <= sh_r;
        end
    end

    assign bus.s_ready   = !buf_full_s;
    assign bus.ser_en    = ser_en_s;
    assign bus.ser_d     = sh_r[0];
    assign bus.word_done = done_s;
endmodule

// File: tb/tb_piso_feeder.sv
// Bench for piso_feeder driving a serial-in shift register; expectations come
// from a word-queue model and a fixed vector table.
module tb_piso_feeder;
    localparam int W = 4;

    logic clk;
    logic rst_n;
    logic [W-1:0] q;

    piso_feeder_if #(.WIDTH(W)) bus ();

    piso_feeder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream serial-in shift register, first bit ends up in q[0].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= '0;
        else if (bus.ser_en) q <= {bus.ser_d, q[W-1:1]};
    end

    int total = 0;
    int bad   = 0;

    // Model: queue of accepted words; front word is the one on the wire.
    logic [W-1:0] mq[$];
    int           midx = 0;
    int           en_cnt = 0;
    int           done_cnt = 0;
    int           rdy_low = 0;

    typedef struct {
        logic         v;
        logic [W-1:0] d;
        logic         h;
        logic         rdy;
        logic         en;
        logic         sd;
        logic         done;
    } vec_t;

    vec_t vt[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic v, input logic [W-1:0] d, input logic h);
        logic         e_rdy, e_en, e_d, e_done, chk_q;
        logic [W-1:0] w;
        logic [W-1:0] fw;
        @(negedge clk);
        bus.s_valid = v;
        bus.s_data  = d;
        bus.hold    = h;
        #1;
        e_rdy  = (mq.size() < 2);
        e_en   = (mq.size() > 0) && !h;
        if (mq.size() > 0) begin
            fw  = mq[0];
            e_d = fw[midx];
        end else begin
            e_d = 1'b0;
        end
        e_done = e_en && (midx == W - 1);
        chk("s_ready", bus.s_ready, e_rdy);
        chk("ser_en", bus.ser_en, e_en);
        chk("ser_d", bus.ser_d, e_d);
        chk("word_done", bus.word_done, e_done);
        en_cnt   += int'(bus.ser_en);
        done_cnt += int'(bus.word_done);
        rdy_low  += int'(!bus.s_ready);
        chk_q = 1'b0;
        w = '0;
        if (e_en) begin
            if (midx == W - 1) begin
                w = mq.pop_front();
                midx = 0;
                chk_q = 1'b1;
            end else begin
                midx++;
            end
        end
        if (v && e_rdy) mq.push_back(d);
        @(posedge clk);
        #1;
        if (chk_q) chk("q_word", q, w);
    endtask

    task automatic drain();
        int n = 0;
        while (mq.size() > 0 && n < 40) begin
            cyc(1'b0, '0, 1'b0);
            n++;
        end
        chk("drain_bound", mq.size(), 0);
    endtask

    initial begin
        logic [W-1:0] words[3];
        logic [W-1:0] q_snap;
        int wi;
        int guard;

        rst_n = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.hold    = 1'b0;
        #3;
        chk("rst_s_ready", bus.s_ready, 1);
        chk("rst_ser_en", bus.ser_en, 0);
        chk("rst_ser_d", bus.ser_d, 0);
        chk("rst_word_done", bus.word_done, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single word 1011 via vector table.
        vt[0] = '{1'b1, 4'b1011, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[1] = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[2] = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[3] = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[4] = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        vt[5] = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.s_valid = vt[i].v;
            bus.s_data  = vt[i].d;
            bus.hold    = vt[i].h;
            #1;
            chk("tv_s_ready", bus.s_ready, vt[i].rdy);
            chk("tv_ser_en", bus.ser_en, vt[i].en);
            chk("tv_ser_d", bus.ser_d, vt[i].sd);
            chk("tv_word_done", bus.word_done, vt[i].done);
            if (i == 5) chk("tv_q", q, 4'b1011);
        end

        // Back-to-back stream A, 5, C.
        words[0] = 4'hA; words[1] = 4'h5; words[2] = 4'hC;
        en_cnt = 0; done_cnt = 0; rdy_low = 0; wi = 0; guard = 0;
        while (wi < 3 && guard < 40) begin
            if (mq.size() < 2) begin
                cyc(1'b1, words[wi], 1'b0);
                wi++;
            end else begin
                cyc(1'b1, words[wi], 1'b0);
            end
            guard++;
        end
        drain();
        chk("b2b_en_cycles", en_cnt, 12);
        chk("b2b_done_pulses", done_cnt, 3);
        chk("b2b_ready_dropped", (rdy_low > 0), 1);

        // Hold for 3 cycles after bit1.
        en_cnt = 0;
        cyc(1'b1, 4'b0110, 1'b0);
        cyc(1'b0, '0, 1'b0);
        cyc(1'b0, '0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1);
        drain();
        chk("hold_en_cycles", en_cnt, 4);

        // Hold on last bit while the buffer is full.
        cyc(1'b1, 4'h9, 1'b0);
        cyc(1'b1, 4'h2, 1'b0);
        cyc(1'b0, '0, 1'b0);
        cyc(1'b0, '0, 1'b0);
        cyc(1'b0, '0, 1'b1);
        cyc(1'b0, '0, 1'b1);
        cyc(1'b0, '0, 1'b0);
        drain();

        // Reset mid-word with a buffered word present.
        cyc(1'b1, 4'hF, 1'b0);
        cyc(1'b1, 4'hE, 1'b0);
        cyc(1'b0, '0, 1'b0);
        @(negedge clk);
        bus.s_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mrst_ser_en", bus.ser_en, 0);
        chk("mrst_s_ready", bus.s_ready, 1);
        chk("mrst_ser_d", bus.ser_d, 0);
        chk("mrst_q", q, 0);
        mq.delete();
        midx = 0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b0, '0, 1'b0);
        chk("post_rst_idle_en", bus.ser_en, 0);
        cyc(1'b1, 4'h3, 1'b0);
        drain();
        chk("post_rst_q", q, 4'h3);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 1)), W'($urandom_range(0, 15)),
                ($urandom_range(0, 4) == 0));
        end
        drain();

        // Idle: nothing moves for 20 cycles.
        q_snap = q;
        en_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 20; i++) cyc(1'b0, W'($urandom_range(0, 15)), 1'b0);
        chk("idle_en", en_cnt, 0);
        chk("idle_done", done_cnt, 0);
        chk("idle_q", q, q_snap);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
